// File: rtl/stack_thread_unit.sv
// Multi-thread operand stack: one registered response per accepted operation.
// Optional STACK_ERR_TRAP_EN: an error halts the thread until CLEAR.
module stack_thread_unit #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 32,
  parameter int THREADS = 2,
  parameter int TW      = (THREADS > 1) ? $clog2(THREADS) : 1,
  parameter int DW      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [TW-1:0]      op_thread,
  input  logic [2:0]         op_code,
  input  logic [11:0]        op_arg,
  input  logic [WIDTH-1:0]   op_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [TW-1:0]      rsp_thread,
  output logic [WIDTH-1:0]   rsp_top,
  output logic [DW-1:0]      rsp_depth,
  output logic               rsp_err,
  output logic [THREADS-1:0] halted
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POPN  = 3'd2;
  localparam logic [2:0] OP_DUP   = 3'd3;
  localparam logic [2:0] OP_GET   = 3'd4;
  localparam logic [2:0] OP_PUT   = 3'd5;
  localparam logic [2:0] OP_BINOP = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  logic [WIDTH-1:0] mem [THREADS][DEPTH];
  logic [DW-1:0]    depth_q [THREADS];

  logic             accept;
  logic             thread_ok;
  logic [TW-1:0]    t;
  logic [DW-1:0]    d;
  logic [31:0]      dd;
  logic [31:0]      aa;
  logic [WIDTH-1:0] top_val;
  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] alu;
  logic             err;
  logic             we;
  logic [AW-1:0]    widx;
  logic [WIDTH-1:0] wdata;
  logic [DW-1:0]    nd;
  logic [WIDTH-1:0] post_top;
  logic             trap_block;

  // Handshake: a request is taken on a rising edge with op_valid && op_ready;
  // the response sits in the output register until rsp_ready is seen high.
  assign op_ready = !rsp_valid || rsp_ready;
  assign accept   = op_valid && op_ready;

`ifdef STACK_ERR_TRAP_EN
  logic [THREADS-1:0] halted_q;
  assign halted     = halted_q;
  assign trap_block = halted_q[t] && (op_code != OP_CLEAR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted_q <= '0;
    end else if (accept && thread_ok) begin
      if (op_code == OP_CLEAR) halted_q[t] <= 1'b0;
      else if (err)            halted_q[t] <= 1'b1;
    end
  end
`else
  assign halted     = '0;
  assign trap_block = 1'b0;
`endif

  always_comb begin
    thread_ok = 32'(op_thread) < THREADS;
    t         = thread_ok ? op_thread : '0;
    d         = depth_q[t];
    dd        = 32'(d);
    aa        = 32'(op_arg);
    top_val   = (d != '0) ? mem[t][AW'(dd - 32'd1)] : '0;
    a_val     = mem[t][AW'(dd - 32'd2)];
    case (op_arg[2:0])
      3'd0:    alu = a_val + top_val;
      3'd1:    alu = a_val & top_val;
      3'd2:    alu = {{(WIDTH-1){1'b0}}, (a_val < top_val)};
      3'd3:    alu = a_val | top_val;
      3'd4:    alu = a_val - top_val;
      3'd5:    alu = a_val ^ top_val;
      default: alu = a_val;
    endcase

    err   = !thread_ok || trap_block;
    we    = 1'b0;
    widx  = '0;
    wdata = '0;
    nd    = d;
    if (!err) begin
      case (op_code)
        OP_PUSH: begin
          if (dd < DEPTH) begin we = 1'b1; widx = AW'(dd); wdata = op_data; nd = DW'(dd + 32'd1); end
          else err = 1'b1;
        end
        OP_POPN: begin
          if (dd >= aa) nd = DW'(dd - aa);
          else err = 1'b1;
        end
        OP_DUP: begin
          if (dd >= 32'd1 && dd < DEPTH) begin we = 1'b1; widx = AW'(dd); wdata = top_val; nd = DW'(dd + 32'd1); end
          else err = 1'b1;
        end
        OP_GET: begin
          if (aa < dd && dd < DEPTH) begin
            we = 1'b1; widx = AW'(dd); wdata = mem[t][AW'(dd - 32'd1 - aa)]; nd = DW'(dd + 32'd1);
          end else err = 1'b1;
        end
        OP_PUT: begin
          if (aa < dd) begin we = 1'b1; widx = AW'(dd - 32'd1 - aa); wdata = top_val; end
          else err = 1'b1;
        end
        OP_BINOP: begin
          if (dd >= 32'd2) begin we = 1'b1; widx = AW'(dd - 32'd2); wdata = alu; nd = DW'(dd - 32'd1); end
          else err = 1'b1;
        end
        OP_CLEAR: nd = '0;
        OP_NOP:   nd = d;
        default:  nd = d;
      endcase
    end
    if (err) begin
      we = 1'b0;
      nd = d;
    end

    // Post-op top must see this cycle's write, since storage updates on the same edge.
    if (nd == '0)                                 post_top = '0;
    else if (we && widx == AW'(nd - 1'b1))        post_top = wdata;
    else                                          post_top = mem[t][AW'(nd - 1'b1)];
  end

  always_ff @(posedge clk) begin
    if (accept && we) mem[t][widx] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_top    <= '0;
      rsp_depth  <= '0;
      rsp_thread <= '0;
      for (int i = 0; i < THREADS; i++) depth_q[i] <= '0;
    end else begin
      if (accept) begin
        rsp_valid  <= 1'b1;
        rsp_thread <= op_thread;
        rsp_err    <= err;
        rsp_depth  <= thread_ok ? nd : '0;
        rsp_top    <= thread_ok ? post_top : '0;
        if (thread_ok) depth_q[t] <= nd;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stack_thread_unit.sv
// Directed and random bench for stack_thread_unit (WIDTH=16, DEPTH=4, THREADS=2)
// against an array-based model of the stack rules.
module tb_stack_thread_unit;
`ifdef STACK_ERR_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [0:0]  op_thread;
  logic [2:0]  op_code;
  logic [11:0] op_arg;
  logic [15:0] op_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:0]  rsp_thread;
  logic [15:0] rsp_top;
  logic [2:0]  rsp_depth;
  logic        rsp_err;
  logic [1:0]  halted;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_mem [2][4];
  int          m_d [2];
  bit          m_halt [2];

  always #5 clk = ~clk;

  stack_thread_unit #(.WIDTH(16), .DEPTH(4), .THREADS(2)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_thread(op_thread),
    .op_code(op_code), .op_arg(op_arg), .op_data(op_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_thread(rsp_thread),
    .rsp_top(rsp_top), .rsp_depth(rsp_depth), .rsp_err(rsp_err),
    .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_top(input int t);
    return (m_d[t] == 0) ? 16'h0 : m_mem[t][m_d[t]-1];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_d[i]    = 0;
      m_halt[i] = 1'b0;
    end
  endtask

  // Applies one operation's rules; any unmet precondition leaves the stack untouched.
  task automatic model_op(input int t, input int code, input int arg, input logic [15:0] data,
                          output bit e);
    int d;
    logic [15:0] a, b, r;
    d = m_d[t];
    e = 1'b0;
    if (TRAP && m_halt[t] && code != 7) e = 1'b1;
    else begin
      case (code)
        1: if (d < 4) begin m_mem[t][d] = data; m_d[t] = d + 1; end else e = 1'b1;
        2: if (d >= arg) m_d[t] = d - arg; else e = 1'b1;
        3: if (d >= 1 && d < 4) begin m_mem[t][d] = m_mem[t][d-1]; m_d[t] = d + 1; end else e = 1'b1;
        4: if (arg < d && d < 4) begin m_mem[t][d] = m_mem[t][d-1-arg]; m_d[t] = d + 1; end else e = 1'b1;
        5: if (arg < d) m_mem[t][d-1-arg] = m_mem[t][d-1]; else e = 1'b1;
        6: if (d >= 2) begin
             a = m_mem[t][d-2];
             b = m_mem[t][d-1];
             case (arg % 8)
               0: r = a + b;
               1: r = a & b;
               2: r = (a < b) ? 16'd1 : 16'd0;
               3: r = a | b;
               4: r = a - b;
               5: r = a ^ b;
               default: r = a;
             endcase
             m_mem[t][d-2] = r;
             m_d[t] = d - 1;
           end else e = 1'b1;
        7: begin m_d[t] = 0; m_halt[t] = 1'b0; end
        default: ;
      endcase
    end
    if (TRAP && e) m_halt[t] = 1'b1;
  endtask

  task automatic check_rsp(input int t, input bit e);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_thread", 32'(rsp_thread), 32'(t));
    chk("rsp_err", 32'(rsp_err), 32'(e));
    chk("rsp_depth", 32'(rsp_depth), 32'(m_d[t]));
    chk("rsp_top", 32'(rsp_top), 32'(exp_top(t)));
    chk("halted", 32'(halted), {30'd0, m_halt[1], m_halt[0]});
  endtask

  task automatic drive(input int t, input int code, input int arg, input logic [15:0] data);
    op_valid  = 1'b1;
    op_thread = 1'(t);
    op_code   = 3'(code);
    op_arg    = 12'(arg);
    op_data   = data;
  endtask

  task automatic do_op(input int t, input int code, input int arg, input logic [15:0] data);
    bit e;
    drive(t, code, arg, data);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    model_op(t, code, arg, data, e);
    check_rsp(t, e);
    op_valid = 1'b0;
  endtask

  initial begin
    bit e;
    int code, arg;
    reset = 1'b0; op_valid = 1'b0; op_thread = '0; op_code = '0;
    op_arg = '0; op_data = '0; rsp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_rsp_top", 32'(rsp_top), 32'd0);
    chk("reset_rsp_depth", 32'(rsp_depth), 32'd0);
    chk("reset_rsp_thread", 32'(rsp_thread), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_op_ready", 32'(op_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Subtract: 5 - 3 = 2
    do_op(0, 1, 0, 16'd5);
    do_op(0, 1, 0, 16'd3);
    do_op(0, 6, 4, 16'd0);
    chk("sub_top", 32'(rsp_top), 32'h2);

    // Overflow on full stack, then DUP, then CLEAR
    do_op(0, 7, 0, 16'd0);
    for (int i = 1; i <= 4; i++) do_op(0, 1, 0, 16'(i));
    do_op(0, 1, 0, 16'd9);
    chk("ovf_err", 32'(rsp_err), 32'd1);
    chk("ovf_top", 32'(rsp_top), 32'h4);
    do_op(0, 3, 0, 16'd0);
    do_op(0, 7, 0, 16'd0);
    chk("clear_depth", 32'(rsp_depth), 32'd0);

    // Response clears when idle with rsp_ready high
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

    // Interleaved threads every cycle
    do_op(1, 7, 0, 16'd0);
    for (int i = 0; i < 4; i++) do_op(i % 2, 1, 0, (i % 2 == 0) ? 16'hAAAA : 16'h5555);

    // GET / PUT on thread 1, then expose index 0
    do_op(1, 7, 0, 16'd0);
    do_op(1, 1, 0, 16'd7);
    do_op(1, 1, 0, 16'd8);
    do_op(1, 1, 0, 16'd9);
    do_op(1, 4, 2, 16'd0);
    chk("get_top", 32'(rsp_top), 32'd7);
    do_op(1, 5, 3, 16'd0);
    do_op(1, 2, 3, 16'd0);
    chk("put_idx0", 32'(rsp_top), 32'd7);

    // Backpressure: response held, pending request not lost
    do_op(0, 7, 0, 16'd0);
    do_op(0, 1, 0, 16'h0011);
    drive(0, 1, 0, 16'h0022);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_op_ready", 32'(op_ready), 32'd0);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_top", 32'(rsp_top), 32'(exp_top(0)));
      chk("stall_rsp_depth", 32'(rsp_depth), 32'(m_d[0]));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    model_op(0, 1, 0, 16'h0022, e);
    check_rsp(0, e);
    op_valid = 1'b0;

    // Reset between acceptance and response consumption
    drive(0, 1, 0, 16'h0033);
    @(posedge clk); #1;
    model_op(0, 1, 0, 16'h0033, e);
    op_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_depth", 32'(rsp_depth), 32'd0);
    chk("midrst_halted", 32'(halted), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    do_op(0, 2, 1, 16'd0);
    chk("post_rst_err", 32'(rsp_err), 32'd1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      code = int'($urandom_range(0, 10));
      if (code > 7) code = 1;
      arg = (code == 6) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 4));
      do_op(int'($urandom_range(0, 1)), code, arg, 16'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        rsp_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
